tdm_demux4: RTL

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_pkg.sv | 10 +
 rtl/tdm_slot_cnt.sv | 21 ++
 rtl/tdm_demux4.sv | 72 +++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot count, slot-index width and demux state encoding
// Contents:
//   NUM_SLOTS - time slots per TDM frame (fixed at 4)
//   SLOT_W    - width of the slot index
//   state_t   - frame alignment state {HUNT, LOCKED}
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
  typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_slot_cnt.sv
// tdm_slot_cnt: modulo-4 slot counter with load-to-1 and hold
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears slot to 0
//   load  - set slot to 1 (slot 0 was just captured on a frame_sync)
//   inc   - advance slot by one, 3 wraps to 0
//   slot  - current slot index
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else if (load) slot <= SLOT_W'(1);
    else if (inc) slot <= slot + SLOT_W'(1);
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM demultiplexer with frame_sync alignment
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   din        - serialized slot samples
//   din_valid  - din carries one slot sample this cycle
//   frame_sync - with din_valid, din is the slot-0 sample
//   out0..out3 - last captured sample of each slot
//   out_valid  - one-cycle strobe per slot when its output updates
//   frame_done - one-cycle pulse when slot 3 is captured
//   locked     - high while aligned to the frame
//   sync_err   - one-cycle pulse on a frame_sync arriving at slot != 0
module tdm_demux4 #(
  parameter int WIDTH = 8,
  parameter int NUM_SLOTS = tdm_pkg::NUM_SLOTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [WIDTH-1:0]     out0,
  output logic [WIDTH-1:0]     out1,
  output logic [WIDTH-1:0]     out2,
  output logic [WIDTH-1:0]     out3,
  output logic [NUM_SLOTS-1:0] out_valid,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err
);
  import tdm_pkg::SLOT_W;
  import tdm_pkg::state_t;
  import tdm_pkg::HUNT;
  import tdm_pkg::LOCKED;
  state_t state;
  logic [WIDTH-1:0] q [NUM_SLOTS];
  logic [SLOT_W-1:0] slot, idx;
  logic sync, inc, acc;
  // A synced sample is always slot 0, in either state; unsynced samples
  // only count once aligned.
  assign sync = din_valid && frame_sync;
  assign inc = din_valid && !frame_sync && state == LOCKED;
  assign acc = sync || inc;
  assign idx = sync ? '0 : slot;
  tdm_slot_cnt u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (sync),
    .inc  (inc),
    .slot (slot)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      locked <= 1'b0;
      out_valid <= '0;
      frame_done <= 1'b0;
      sync_err <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) q[i] <= '0;
    end else begin
      state <= sync ? LOCKED : state;
      locked <= sync || state == LOCKED;
      out_valid <= acc ? NUM_SLOTS'(1) << idx : '0;
      frame_done <= acc && idx == SLOT_W'(NUM_SLOTS - 1);
      sync_err <= sync && state == LOCKED && slot != '0;
      if (acc) q[idx] <= din;
    end
  assign out0 = q[0];
  assign out1 = q[1];
  assign out2 = q[2];
  assign out3 = q[3];
endmodule
